// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiplier: operand width, FSM encoding
// and the funct codes the decoder and ALU control use for the HI/LO ops.
package mult_hilo_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned radix-2 shift-add datapath: one partial product per step, with a
// step counter that flags the final iteration.
module mult_shift_add_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  last_step,
    output logic [2*DATA_W-1:0]   product
);

    logic [DATA_W-1:0] mcand;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   sum;

    // The low half of the accumulator doubles as the multiplier shift register:
    // each step consumes bit 0 and shifts the growing product in from the top.
    assign sum       = {1'b0, product[2*DATA_W-1:DATA_W]}
                     + {1'b0, (product[0] ? mcand : {DATA_W{1'b0}})};
    assign last_step = step && (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            cnt     <= '0;
        end else if (load) begin
            product <= {{DATA_W{1'b0}}, multiplier};
            mcand   <= multiplicand;
            cnt     <= '0;
        end else if (step) begin
            product <= {sum, product[DATA_W-1:1]};
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// Iterative 32x32 mult/multu with architectural HI/LO registers and mthi/mtlo
// write port; sign is stripped up front and reapplied in the FIX state.
module mult_hilo_unit #(
    parameter int DATA_W = mult_hilo_unit_pkg::DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    import mult_hilo_unit_pkg::*;

    state_t              state;
    logic                neg;
    logic                load;
    logic                step;
    logic                last_step;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [2*DATA_W-1:0] product;

    assign load   = (state == ST_IDLE) && start_i;
    assign step   = (state == ST_RUN);
    assign busy_o = (state != ST_IDLE);

    // The most negative value negates to itself, which is its correct magnitude
    // when read as unsigned.
    assign mag1 = (signed_i && src1_i[DATA_W-1]) ? (~src1_i + 1'b1) : src1_i;
    assign mag2 = (signed_i && src2_i[DATA_W-1]) ? (~src2_i + 1'b1) : src2_i;

    mult_shift_add_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk          (clk_i),
        .rst          (rst_i),
        .load         (load),
        .step         (step),
        .multiplicand (mag1),
        .multiplier   (mag2),
        .last_step    (last_step),
        .product      (product)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            neg    <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        neg   <= signed_i & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
                        state <= ST_RUN;
                    end else begin
                        if (mthi_i) hi_o <= wdata_i;
                        if (mtlo_i) lo_o <= wdata_i;
                    end
                end
                ST_RUN: begin
                    if (last_step) state <= ST_FIX;
                end
                ST_FIX: begin
                    {hi_o, lo_o} <= neg ? -product : product;
                    done_o       <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed and random checks of mult_hilo_unit against a plain-arithmetic
// 64-bit product model.
module tb_mult_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    wire         busy;
    wire         done;
    wire  [31:0] hi;
    wire  [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_hilo_unit dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .signed_i (sgn),
        .src1_i   (src1),
        .src2_i   (src2),
        .mthi_i   (mthi),
        .mtlo_i   (mtlo),
        .wdata_i  (wdata),
        .busy_o   (busy),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'b0, a} * {32'b0, b});
        return p;
    endfunction

    // Called at a negedge with the unit idle (possibly in its done cycle).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic with_mtlo);
        logic [63:0] exp;
        int          n;
        logic        early;
        exp   = model(a, b, s);
        start = 1'b1; sgn = s; src1 = a; src2 = b;
        mtlo  = with_mtlo; wdata = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        n = 0; early = 1'b0;
        while (busy && n < 60) begin
            if (done) early = 1'b1;
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'd33);
        check("no_early_done", 64'(early), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("hi", 64'(hi), 64'(exp[63:32]));
        check("lo", 64'(lo), 64'(exp[31:0]));
    endtask

    initial begin
        int          pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // mthi / mtlo in IDLE
        mthi = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_lo", 64'(lo), 64'd0);
        mtlo = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo_hi", 64'(hi), 64'h12345678);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00000055;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("mtboth_hi", 64'(hi), 64'h55);
        check("mtboth_lo", 64'(lo), 64'h55);

        // directed products
        run_mul(32'd3, 32'd5, 1'b0, 1'b0);
        check("lo_3x5", 64'(lo), 64'h0000000F);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("hi_ffxff", 64'(hi), 64'hFFFFFFFE);
        run_mul(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        check("lo_m2x3", 64'(lo), 64'hFFFFFFFA);
        run_mul(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        check("hi_minxmin", 64'(hi), 64'h40000000);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("lo_m1xm1", 64'(lo), 64'd1);
        @(negedge clk);

        // start and mthi while busy are ignored
        start = 1'b1; sgn = 1'b0; src1 = 32'd7; src2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                start = 1'b1; src1 = 32'd2; src2 = 32'd2; mthi = 1'b1; wdata = 32'hDEAD;
            end
            if (c == 11) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (done) pulses++;
            @(negedge clk);
        end
        check("busy_ignore_hi", 64'(hi), 64'd0);
        check("busy_ignore_lo", 64'(lo), 64'h3F);
        check("busy_ignore_pulses", 64'(pulses), 64'd1);

        // asynchronous reset mid-run
        start = 1'b1; sgn = 1'b0; src1 = 32'd7; src2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("arst_no_done", 64'(pulses), 64'd0);
        run_mul(32'd2, 32'd3, 1'b0, 1'b0);
        check("after_rst_lo", 64'(lo), 64'd6);
        @(negedge clk);

        // start wins over a same-cycle mtlo
        run_mul(32'd4, 32'd5, 1'b0, 1'b1);
        check("start_vs_mtlo", 64'(lo), 64'd20);

        // random back-to-back operations, each started in the previous done cycle
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 3) a = 32'h80000000;
            if (i == 5) b = 32'h80000000;
            run_mul(a, b, s, 1'b0);
        end
        @(negedge clk);
        check("final_done_low", 64'(done), 64'd0);
        check("final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
Iterative 32x32 multiplier with architectural HI/LO registers. It sits in the execute stage beside the ALU and consumes the same two operand buses. The decoder/ALU-control path raises start_i for mult/multu. The hazard unit stalls on busy_o, and the writeback mux reads hi_o/lo_o for mfhi/mflo.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  begin a multiply; sampled only in IDLE
signed_i  input  1  1 = mult (two's complement), 0 = multu; sampled with start_i
src1_i  input  DATA_W  multiplicand (rs)
src2_i  input  DATA_W  multiplier (rt)
mthi_i  input  1  write wdata_i to HI
mtlo_i  input  1  write wdata_i to LO
wdata_i  input  DATA_W  mthi/mtlo data (rs)
busy_o  output  1  high while an operation is in flight
done_o  output  1  one-cycle pulse when HI/LO hold a new product
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE, HI=0, LO=0, counter=0, internal accumulator=0. Outputs: busy_o=0, done_o=0, hi_o=0, lo_o=0.
- A reset mid-operation aborts the operation. No done_o is generated for it.
- FSM states: IDLE, RUN, FIX. busy_o = (state != IDLE), decoded combinationally from the state register.
- IDLE, start_i=1 at edge E0:
  - Latch the magnitudes of the operands. If signed_i=1, use |src| for each; 0x80000000 maps to 0x80000000 read as unsigned.
  - Latch neg = signed_i & (src1[MSB] ^ src2[MSB]).
  - Clear the 2*DATA_W accumulator and the counter; go to RUN.
- RUN: one shift-add step per cycle (add the multiplicand if the current multiplier bit is 1, then shift).
  - The counter increments each cycle.
  - After DATA_W steps (edge E32) go to FIX.
- FIX: at edge E33:
  - HI:LO <= neg ? two's-complement negate of the accumulator (2*DATA_W-bit) : accumulator.
  - done_o <= 1 (registered). State returns to IDLE.
- Timing: done_o is high for exactly the one cycle following E33, and HI/LO are valid from that same cycle. busy_o is high from after E0 through E33. Total latency is DATA_W+1 edges.
- start_i while busy: ignored. It is not queued and does not disturb the operation in flight.
- mthi_i/mtlo_i:
  - In IDLE, write on the next edge. Both may be asserted together, in which case both registers are written.
  - While busy they are ignored. The hazard unit guarantees they are not issued then.
- start_i and mthi_i/mtlo_i in the same IDLE cycle: start wins and the mt writes are dropped. The product overwrites HI/LO at completion.
- HI/LO hold their value at all other times. hi_o/lo_o are direct register outputs.
- A new start_i is accepted in the cycle done_o is high, because the state is already IDLE.
- Width rules: the accumulator is 2*DATA_W bits and addition is unsigned with no overflow loss. Negation is modulo 2^(2*DATA_W).

Decomposition:
- Shared package (e.g. cpu_pkg): DATA_W, the FSM state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2), and the mult/multu/mfhi/mflo/mthi/mtlo funct constants shared with the decoder and ALU control.
- One natural sub-module, mult_shift_add_core: it holds the accumulator, multiplier shift register and counter, with load/step inputs and a last_step output. The HI/LO registers and FSM stay in mult_hilo_unit.

Test Plan:
1. Unsigned 3 x 5: start with signed_i=0, src1=3, src2=5 -> busy_o high for 33 cycles; done_o pulses one cycle after E33; HI=0x00000000, LO=0x0000000F.
2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Signed -2 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
3. Signed boundary 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000. Signed -1 x -1 -> HI=0, LO=1.
4. Start 7 x 9; at cycle 10 assert start_i with 2 x 2, plus mthi_i with wdata 0xDEAD -> second start and mthi ignored; final HI=0, LO=0x3F; exactly one done_o pulse.
5. Start 7 x 9; assert rst_i asynchronously mid-RUN (cycle 15) -> busy_o=0, HI=LO=0 immediately with no clock edge needed; no done_o; a following 2 x 3 completes normally with LO=6.
6. IDLE: mthi_i=1, wdata 0x12345678, then mtlo_i=1, wdata 0x9ABCDEF0 -> hi_o/lo_o update on the next edge. Same-cycle start_i with mtlo_i -> LO holds the product, not wdata. Back-to-back start in the done_o cycle is accepted.
